instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch unit, the producer side of the instruction interface.
- Owns the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Holds each fetched word and presents it to the decoder on a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes any fetch already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment applied after each instruction is consumed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  fetch enable; when low, no new request is issued (the current transaction still completes).
- imem_req  output  1  request to instruction memory.
- imem_addr  output  32  word address of the request (equals pc).
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid; one response per granted request, in order.
- imem_rdata  input  32  instruction word.
- redirect  input  1  single-cycle pulse: load redirect_pc, flush.
- redirect_pc  input  32  redirect target.
- inst_valid  output  1  instruction/pc outputs hold a valid instruction.
- inst_ready  input  1  decoder consumes the instruction this cycle.
- instruction  output  32  fetched word.
- inst_pc  output  32  address of `instruction`.
- fetch_err  output  1  misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=IDLE; drop=0.
  - imem_req=0, inst_valid=0, instruction=0, inst_pc=0, fetch_err=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: if en goes to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc, held stable until imem_gnt. Gnt -> WAIT. If en drops before gnt, imem_req is held anyway; a started request is never retracted.
  - WAIT: imem_req=0. On imem_rvalid:
    - drop=1: discard data, clear drop, go to REQ (or IDLE if en=0).
    - otherwise: instruction<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - HOLD: inst_valid=1, outputs stable. On inst_ready: pc<=pc+PC_STEP (mod 2^32, wraps silently), inst_valid<=0, go to REQ if en else IDLE.
- Best-case throughput: one instruction per 3 cycles with gnt and rvalid each arriving one cycle after request. No prefetch.
- Redirect (highest priority; any state):
  - pc<=redirect_pc; inst_valid<=0 next cycle.
  - Redirect in WAIT, or in REQ with gnt the same cycle: drop<=1, state=WAIT so the stale response is absorbed.
  - Otherwise: state<=REQ if en else IDLE.
  - Redirect and inst_ready in the same HOLD cycle: redirect wins, no pc+step.
  - Redirect and rvalid in the same WAIT cycle with drop=0: data discarded, drop stays 0, go to REQ.
- inst_valid never falls without inst_ready or redirect.
- instruction/inst_pc change only when inst_valid rises.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 is ignored for pc/state (no flush). fetch_err pulses high for exactly one cycle, and the error is sticky in no other way.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - fetch_err is tied to 0.

Test Plan:
- Reset with RESET_PC=0, en=1, memory gnt/rvalid after 1 cycle returning 32'h00500093 -> imem_addr=0. inst_valid rises with instruction=32'h00500093, inst_pc=0. After inst_ready, next imem_addr=4.
- Decoder stalls inst_ready=0 for 5 cycles -> instruction/inst_pc stable, no imem_req issued. Ready -> pc advances by exactly 4.
- Redirect to 32'h100 while in WAIT -> the stale rvalid word is discarded (inst_valid stays 0). Next request imem_addr=32'h100.
- Redirect to 32'h200 coinciding with inst_ready in HOLD -> next imem_addr=32'h200, not pc+4.
- pc=32'hFFFF_FFFC consumed -> next imem_addr=0.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 32'h102 -> fetch_err one-cycle pulse, pc unchanged. Undefined -> next imem_addr=32'h100, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch unit. Owns the PC, issues single word
//            requests over a req/gnt/rvalid memory handshake, holds each
//            fetched word for the decoder on a valid/ready handshake, and
//            accepts branch/jump redirects that flush an in-flight fetch.
// Options  : FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a
//            non-word-aligned target is rejected and fetch_err pulses for
//            one cycle. When undefined, the target is forced word-aligned
//            and fetch_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        drop;
  logic        drop_next;
  logic        load_inst;
  logic        redirect_take;
  logic [31:0] redirect_target;
  logic        err_next;
  logic        err_q;

  // Redirect qualification: decides whether a redirect is honoured, the
  // target it loads, and whether it raises the misalignment flag.
`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    redirect_take   = redirect && (redirect_pc[1:0] == 2'b00);
    redirect_target = redirect_pc;
    err_next        = redirect && (redirect_pc[1:0] != 2'b00);
  end
`else
  always_comb begin
    redirect_take   = redirect;
    redirect_target = redirect_pc & ~32'h0000_0003;
    err_next        = 1'b0;
  end
`endif

  // Next-state logic: normal fetch sequencing first, then a redirect
  // overrides everything because it has the highest priority.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    load_inst  = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // The request stays up until granted, even if en falls meanwhile.
        if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop) begin
            // Response belongs to a flushed fetch: absorb it and refetch.
            drop_next  = 1'b0;
            state_next = en ? REQ : IDLE;
          end else begin
            load_inst  = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          pc_next    = pc + PC_STEP;
          state_next = en ? REQ : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (redirect_take) begin
      pc_next   = redirect_target;
      load_inst = 1'b0;
      if (((state == WAIT) && !imem_rvalid) || ((state == REQ) && imem_gnt)) begin
        // A response is still owed for the old address; mark it stale.
        drop_next  = 1'b1;
        state_next = WAIT;
      end else if ((state == WAIT) && imem_rvalid) begin
        // The outstanding response arrives this cycle and is discarded,
        // so nothing is left in flight.
        drop_next  = 1'b0;
        state_next = en ? REQ : IDLE;
      end else begin
        state_next = en ? REQ : IDLE;
      end
    end
  end

  // State, PC and flush-tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      drop  <= drop_next;
      err_q <= err_next;
    end
  end

  // Instruction holding registers; updated only when a valid word lands,
  // so they stay stable for the whole time inst_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= 32'h0000_0000;
      inst_pc     <= 32'h0000_0000;
    end else if (load_inst) begin
      instruction <= imem_rdata;
      inst_pc     <= pc;
    end
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    imem_req   = (state == REQ);
    imem_addr  = pc;
    inst_valid = (state == HOLD);
    fetch_err  = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch. The bench drives
//            the memory and decoder handshakes step by step and compares
//            outputs against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_err;

  int checks;
  int errors;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .fetch_err   (fetch_err)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 unit so outputs are sampled
  // and inputs are driven away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    en          = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;

    step();
    step();
    check("rst_req",   {31'h0, imem_req},   32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_instr", instruction,         32'h0);
    check("rst_ipc",   inst_pc,             32'h0);
    check("rst_err",   {31'h0, fetch_err},  32'h0);
    check("rst_addr",  imem_addr,           32'h0);

    rst = 1'b1;
    en  = 1'b1;
    step();                                  // IDLE -> REQ
    check("req0",      {31'h0, imem_req},   32'h1);
    check("req0_addr", imem_addr,           32'h0);
    step();                                  // no grant yet: request held
    check("req0_hold", {31'h0, imem_req},   32'h1);
    check("req0_hadr", imem_addr,           32'h0);

    imem_gnt = 1'b1;
    step();                                  // REQ -> WAIT
    imem_gnt = 1'b0;
    check("wait_req",   {31'h0, imem_req},   32'h0);
    check("wait_valid", {31'h0, inst_valid}, 32'h0);

    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();                                  // WAIT -> HOLD
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("hold_valid", {31'h0, inst_valid}, 32'h1);
    check("hold_instr", instruction,         32'h0050_0093);
    check("hold_ipc",   inst_pc,             32'h0);

    // Decoder stall: outputs frozen, no new request.
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'h0, inst_valid}, 32'h1);
      check("stall_instr", instruction,         32'h0050_0093);
      check("stall_ipc",   inst_pc,             32'h0);
      check("stall_req",   {31'h0, imem_req},   32'h0);
    end

    inst_ready = 1'b1;
    step();                                  // consume -> REQ at pc+4
    inst_ready = 1'b0;
    check("cons_valid", {31'h0, inst_valid}, 32'h0);
    check("cons_req",   {31'h0, imem_req},   32'h1);
    check("cons_addr",  imem_addr,           32'h4);

    // Redirect while waiting: the stale response must be dropped.
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    check("rdw_req",   {31'h0, imem_req},   32'h0);
    check("rdw_valid", {31'h0, inst_valid}, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("rdw_drop_valid", {31'h0, inst_valid}, 32'h0);
    check("rdw_req2",       {31'h0, imem_req},   32'h1);
    check("rdw_addr",       imem_addr,           32'h0000_0100);

    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("f100_valid", {31'h0, inst_valid}, 32'h1);
    check("f100_instr", instruction,         32'h1111_1111);
    check("f100_ipc",   inst_pc,             32'h0000_0100);

    // Redirect coinciding with consume: redirect wins.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    inst_ready  = 1'b1;
    step();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    check("rdh_valid", {31'h0, inst_valid}, 32'h0);
    check("rdh_req",   {31'h0, imem_req},   32'h1);
    check("rdh_addr",  imem_addr,           32'h0000_0200);

    // Redirect in REQ without grant, to the top word, then wrap on consume.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_2222;
    step();
    imem_rvalid = 1'b0;
    check("top_ipc",   inst_pc,     32'hFFFF_FFFC);
    check("top_instr", instruction, 32'h2222_2222);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("wrap_req",  {31'h0, imem_req}, 32'h1);
    check("wrap_addr", imem_addr,         32'h0);

    // Misaligned redirect.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_err",  {31'h0, fetch_err}, 32'h1);
    check("mis_addr", imem_addr,          32'h0);
`else
    check("mis_err",  {31'h0, fetch_err}, 32'h0);
    check("mis_addr", imem_addr,          32'h0000_0100);
`endif
    check("mis_req", {31'h0, imem_req}, 32'h1);
    step();
    check("mis_err2", {31'h0, fetch_err}, 32'h0);

    // Redirect together with rvalid in WAIT (drop clear): data discarded,
    // and the following fetch must be accepted normally.
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_3333;
    step();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    check("rdv_valid", {31'h0, inst_valid}, 32'h0);
    check("rdv_req",   {31'h0, imem_req},   32'h1);
    check("rdv_addr",  imem_addr,           32'h0000_0300);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4444_4444;
    step();
    imem_rvalid = 1'b0;
    check("rdv2_valid", {31'h0, inst_valid}, 32'h1);
    check("rdv2_instr", instruction,         32'h4444_4444);
    check("rdv2_ipc",   inst_pc,             32'h0000_0300);

    // Fetch disabled: consume goes to IDLE and no request follows.
    en         = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("dis_valid", {31'h0, inst_valid}, 32'h0);
    check("dis_req",   {31'h0, imem_req},   32'h0);
    step();
    check("dis_req2",  {31'h0, imem_req},   32'h0);
    check("dis_addr",  imem_addr,           32'h0000_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
